// File: rtl/alu_muldiv_pkg.sv
// Shared constants for the ALU op interface and the multiply/divide controller.
// Opcodes match the existing 4-bit combinational ALU.
package alu_muldiv_pkg;

   localparam int ALU_W = 4;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_NOT = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;
   localparam logic [2:0] ALU_OR  = 3'b100;
   localparam logic [2:0] ALU_XOR = 3'b101;
   localparam logic [2:0] ALU_LT  = 3'b110;
   localparam logic [2:0] ALU_EQ  = 3'b111;

   localparam logic MODE_MUL = 1'b0;
   localparam logic MODE_DIV = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } ctrl_state_t;

endpackage

// File: rtl/alu.sv
// Existing 4-bit combinational ALU; subtract reports carry=1 when no borrow occurs.
module alu
   import alu_muldiv_pkg::*;
(
   input  logic [2:0]       op,
   input  logic [ALU_W-1:0] in_x,
   input  logic [ALU_W-1:0] in_y,
   output logic [ALU_W-1:0] out_s,
   output logic             out_c,
   output logic             zero,
   output logic             overflow
);
   logic [ALU_W:0] sum_ext;

   always_comb begin
      sum_ext  = '0;
      out_s    = '0;
      out_c    = 1'b0;
      overflow = 1'b0;
      case (op)
         ALU_ADD: begin
            sum_ext  = {1'b0, in_x} + {1'b0, in_y};
            out_s    = sum_ext[ALU_W-1:0];
            out_c    = sum_ext[ALU_W];
            overflow = (in_x[ALU_W-1] == in_y[ALU_W-1]) && (out_s[ALU_W-1] != in_x[ALU_W-1]);
         end
         ALU_SUB: begin
            sum_ext  = {1'b0, in_x} + {1'b0, ~in_y} + {{ALU_W{1'b0}}, 1'b1};
            out_s    = sum_ext[ALU_W-1:0];
            out_c    = sum_ext[ALU_W];
            overflow = (in_x[ALU_W-1] != in_y[ALU_W-1]) && (out_s[ALU_W-1] != in_x[ALU_W-1]);
         end
         ALU_NOT: out_s = ~in_x;
         ALU_AND: out_s = in_x & in_y;
         ALU_OR:  out_s = in_x | in_y;
         ALU_XOR: out_s = in_x ^ in_y;
         ALU_LT:  out_s = {{(ALU_W-1){1'b0}}, (in_x < in_y)};
         default: out_s = {{(ALU_W-1){1'b0}}, (in_x == in_y)};
      endcase
      zero = (out_s == '0);
   end
endmodule

// File: rtl/alu_muldiv_top.sv
// Integration wrapper joining the controller to the shared 4-bit ALU.
// ALU flags are exported for other consumers; the controller does not use them.
module alu_muldiv_top
   import alu_muldiv_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [ALU_W-1:0] opa,
   input  logic [ALU_W-1:0] opb,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [ALU_W-1:0] res_hi,
   output logic [ALU_W-1:0] res_lo,
   output logic             alu_zero,
   output logic             alu_overflow
);
   logic [2:0]       alu_op;
   logic [ALU_W-1:0] alu_x, alu_y, alu_s;
   logic             alu_c;

   alu u_alu (
      .op       (alu_op),
      .in_x     (alu_x),
      .in_y     (alu_y),
      .out_s    (alu_s),
      .out_c    (alu_c),
      .zero     (alu_zero),
      .overflow (alu_overflow)
   );

   alu_muldiv_ctrl #(.W(ALU_W)) u_ctrl (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .mode   (mode),
      .opa    (opa),
      .opb    (opb),
      .busy   (busy),
      .done   (done),
      .err    (err),
      .res_hi (res_hi),
      .res_lo (res_lo),
      .alu_op (alu_op),
      .alu_x  (alu_x),
      .alu_y  (alu_y),
      .alu_s  (alu_s),
      .alu_c  (alu_c)
   );
endmodule

// File: rtl/alu_muldiv_ctrl.sv
// Multi-cycle unsigned multiply (shift-add) / restoring divide controller that
// drives the external ALU one operation per clock.
module alu_muldiv_ctrl
   import alu_muldiv_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         mode,
   input  logic [W-1:0] opa,
   input  logic [W-1:0] opb,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [W-1:0] res_hi,
   output logic [W-1:0] res_lo,
   output logic [2:0]   alu_op,
   output logic [W-1:0] alu_x,
   output logic [W-1:0] alu_y,
   input  logic [W-1:0] alu_s,
   input  logic         alu_c
);
   localparam int CW = (W > 1) ? $clog2(W) : 1;

   ctrl_state_t   state_reg;
   logic          mode_reg;
   logic [W-1:0]  hi_reg;      // acc_hi (multiply) or remainder R (divide)
   logic [W-1:0]  lo_reg;      // acc_lo (multiply) or quotient Q (divide)
   logic [W-1:0]  b_reg;       // multiplicand or divisor
   logic [CW-1:0] cnt_reg;
   logic          busy_reg, done_reg, err_reg;
   logic [W-1:0]  res_hi_reg, res_lo_reg;

   logic [W-1:0]  rs;
   logic          ok;
   logic [2*W:0]  mul_vec;
   logic [W-1:0]  hi_next, lo_next;

   assign rs      = {hi_reg[W-2:0], lo_reg[W-1]};
   assign ok      = hi_reg[W-1] | alu_c;
   assign mul_vec = {alu_c, alu_s, lo_reg};

   always_comb begin
      alu_op  = ALU_ADD;
      alu_x   = '0;
      alu_y   = '0;
      hi_next = hi_reg;
      lo_next = lo_reg;
      if (state_reg == ST_RUN) begin
         if (mode_reg == MODE_MUL) begin
            alu_x   = hi_reg;
            alu_y   = lo_reg[0] ? b_reg : '0;
            hi_next = mul_vec[2*W:W+1];
            lo_next = mul_vec[W:1];
         end else begin
            alu_op  = ALU_SUB;
            alu_x   = rs;
            alu_y   = b_reg;
            hi_next = ok ? alu_s : rs;
            lo_next = {lo_reg[W-2:0], ok};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         mode_reg   <= MODE_MUL;
         hi_reg     <= '0;
         lo_reg     <= '0;
         b_reg      <= '0;
         cnt_reg    <= '0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
         err_reg    <= 1'b0;
         res_hi_reg <= '0;
         res_lo_reg <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               done_reg <= 1'b0;
               if (start) begin
                  mode_reg <= mode;
                  err_reg  <= 1'b0;
                  cnt_reg  <= '0;
                  hi_reg   <= '0;
                  lo_reg   <= opa;
                  b_reg    <= opb;
                  if (mode == MODE_DIV && opb == '0) begin
                     err_reg    <= 1'b1;
                     res_hi_reg <= opa;
                     res_lo_reg <= '1;
                     done_reg   <= 1'b1;
                     state_reg  <= ST_DONE;
                  end else begin
                     busy_reg  <= 1'b1;
                     state_reg <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               hi_reg  <= hi_next;
               lo_reg  <= lo_next;
               cnt_reg <= cnt_reg + 1'b1;
               // Results are captured on the final step so they are valid alongside done.
               if (cnt_reg == CW'(W-1)) begin
                  busy_reg   <= 1'b0;
                  done_reg   <= 1'b1;
                  res_hi_reg <= hi_next;
                  res_lo_reg <= lo_next;
                  state_reg  <= ST_DONE;
               end
            end
            ST_DONE: begin
               done_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end
            default: begin
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy   = busy_reg;
   assign done   = done_reg;
   assign err    = err_reg;
   assign res_hi = res_hi_reg;
   assign res_lo = res_lo_reg;
endmodule
